// File: rtl/fir_pkg.sv
// Shared helpers for the multi-channel FIR: width derivation, stage-valid bundle and the output round/saturate step.
package fir_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  function automatic int chan_w(input int channels);
    return clog2(channels) + 1;
  endfunction

  typedef struct packed {
    logic s1;
    logic s2;
    logic s3;
    logic s4;
  } stage_vld_t;

  // Round half up, arithmetic shift, optional clamp to a data_w-bit signed range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc, input int shift,
                                                   input int data_w, input logic sat);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc;
    if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
    r  = r >>> shift;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (sat) begin
      if (r > hi) r = hi;
      else if (r < lo) r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_tap_bank.sv
// Per-channel delay lines; win is the write channel's line with the incoming sample shifted in at tap 0.
// Written only on a good-channel accept, so idle cycles and other channels leave a line untouched; clr zeroes all.
module fir_tap_bank
  import fir_pkg::*;
#(
  parameter int TAPS     = 5,
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             wr_en,
  input  logic [chan_w(CHANNELS)-1:0]      wr_chan,
  input  logic [DATA_W-1:0]                wr_data,
  output logic [TAPS-1:0][DATA_W-1:0]      win
);

  logic [TAPS-1:0][DATA_W-1:0] line_q [CHANNELS];
  logic [TAPS-1:0][DATA_W-1:0] line_d [CHANNELS];

  always_comb begin
    win    = '0;
    win[0] = wr_data;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(wr_chan) == c) begin
        for (int k = 1; k < TAPS; k++) win[k] = line_q[c][k-1];
      end
    end
    for (int c = 0; c < CHANNELS; c++) begin
      line_d[c] = line_q[c];
      if (clr) line_d[c] = '0;
      else if (wr_en && int'(wr_chan) == c) line_d[c] = win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) line_q[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) line_q[c] <= line_d[c];
    end
  end

endmodule

// File: rtl/fir_stream_mc.sv
// Multi-channel streaming FIR, 4-stage pipeline (result 4 cycles after accept); FIR_SAT_EN selects saturate vs wrap.
// A stalled result (m_valid && !m_ready) freezes every stage and drops s_ready; clr empties the pipeline and history.
module fir_stream_mc
  import fir_pkg::*;
#(
  parameter int TAPS     = 5,
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int CHANNELS = 2,
  parameter int SHIFT    = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_W-1:0]            s_data,
  input  logic [chan_w(CHANNELS)-1:0]  s_chan,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_W-1:0]            m_data,
  output logic [chan_w(CHANNELS)-1:0]  m_chan,
  input  logic                         coef_we,
  input  logic [clog2(TAPS)-1:0]       coef_addr,
  input  logic [COEF_W-1:0]            coef_data,
  output logic                         err_chan,
  output logic [15:0]                  out_count
);

  localparam int CW    = chan_w(CHANNELS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
`ifdef FIR_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic stall, en, accept, chan_ok;
  logic [TAPS-1:0][DATA_W-1:0] win;

  logic                        rdy_q, rdy_d;
  stage_vld_t                  vld_q, vld_d;
  logic [TAPS-1:0][COEF_W-1:0] coef_q, coef_d, coef1_q, coef1_d;
  logic [TAPS-1:0][DATA_W-1:0] win1_q, win1_d;
  logic [TAPS-1:0][PW-1:0]     prod2_q, prod2_d;
  logic [ACC_W-1:0]            sum3_q, sum3_d;
  logic [CW-1:0]               chan1_q, chan1_d, chan2_q, chan2_d, chan3_q, chan3_d;
  logic [CW-1:0]               m_chan_q, m_chan_d;
  logic [DATA_W-1:0]           m_data_q, m_data_d;
  logic                        err_q, err_d;
  logic [15:0]                 cnt_q, cnt_d;

  logic signed [PW-1:0]        xa [TAPS];
  logic signed [PW-1:0]        cb [TAPS];
  logic [TAPS-1:0][PW-1:0]     prod_c;
  logic [ACC_W-1:0]            sum_c;

  assign stall   = vld_q.s4 && !m_ready;
  assign en      = !stall;
  assign s_ready = rdy_q && !stall && !clr;
  assign accept  = s_valid && s_ready;
  assign chan_ok = int'(s_chan) < CHANNELS;

  fir_tap_bank #(.TAPS(TAPS), .DATA_W(DATA_W), .CHANNELS(CHANNELS)) u_tap_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (accept && chan_ok),
    .wr_chan (s_chan),
    .wr_data (s_data),
    .win     (win)
  );

  // Products and sum carry enough headroom that no intermediate result can overflow.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < TAPS; k++) begin
      xa[k]     = {{COEF_W{win1_q[k][DATA_W-1]}}, win1_q[k]};
      cb[k]     = {{DATA_W{coef1_q[k][COEF_W-1]}}, coef1_q[k]};
      prod_c[k] = xa[k] * cb[k];
      sum_c     = sum_c + {{(ACC_W-PW){prod2_q[k][PW-1]}}, prod2_q[k]};
    end
  end

  always_comb begin
    rdy_d    = 1'b1;
    vld_d    = vld_q;
    coef_d   = coef_q;
    coef1_d  = coef1_q;
    win1_d   = win1_q;
    prod2_d  = prod2_q;
    sum3_d   = sum3_q;
    chan1_d  = chan1_q;
    chan2_d  = chan2_q;
    chan3_d  = chan3_q;
    m_chan_d = m_chan_q;
    m_data_d = m_data_q;
    err_d    = accept && !chan_ok;
    cnt_d    = cnt_q;
    if (vld_q.s4 && m_ready) cnt_d = cnt_q + 16'd1;

    for (int k = 0; k < TAPS; k++) begin
      if (coef_we && int'(coef_addr) == k) coef_d[k] = coef_data;
    end

    // Coefficients are snapshotted with the window so a write never reaches a sample already accepted.
    if (en) begin
      vld_d.s1 = accept && chan_ok;
      vld_d.s2 = vld_q.s1;
      vld_d.s3 = vld_q.s2;
      vld_d.s4 = vld_q.s3;
      win1_d   = win;
      coef1_d  = coef_q;
      chan1_d  = s_chan;
      prod2_d  = prod_c;
      chan2_d  = chan1_q;
      sum3_d   = sum_c;
      chan3_d  = chan2_q;
      m_data_d = DATA_W'(sat_round({{(64-ACC_W){sum3_q[ACC_W-1]}}, sum3_q}, SHIFT, DATA_W, SAT_EN));
      m_chan_d = chan3_q;
    end
    if (clr) vld_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      vld_q    <= '0;
      coef_q   <= '0;
      coef1_q  <= '0;
      win1_q   <= '0;
      prod2_q  <= '0;
      sum3_q   <= '0;
      chan1_q  <= '0;
      chan2_q  <= '0;
      chan3_q  <= '0;
      m_chan_q <= '0;
      m_data_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rdy_q    <= rdy_d;
      vld_q    <= vld_d;
      coef_q   <= coef_d;
      coef1_q  <= coef1_d;
      win1_q   <= win1_d;
      prod2_q  <= prod2_d;
      sum3_q   <= sum3_d;
      chan1_q  <= chan1_d;
      chan2_q  <= chan2_d;
      chan3_q  <= chan3_d;
      m_chan_q <= m_chan_d;
      m_data_q <= m_data_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_valid   = vld_q.s4;
  assign m_data    = m_data_q;
  assign m_chan    = m_chan_q;
  assign err_chan  = err_q;
  assign out_count = cnt_q;

endmodule
